// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one i2c_master and a TCA9548A mux among NUM_CLIENTS requesters.
// Define I2C_MUX_CACHE_EN to skip the mux channel-select write when the granted channel is already selected.
module i2c_bus_arbiter #(
  parameter int         NUM_CLIENTS    = 4,
  parameter int         CLOCK_SPEED_HZ = 50_000_000,
  parameter int         GAP_CYCLES     = CLOCK_SPEED_HZ / 100_000,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [6:0] MUX_ADDR       = 7'h70
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CLIENTS-1:0]    req,
  input  logic [7*NUM_CLIENTS-1:0]  c_addr,
  input  logic [NUM_CLIENTS-1:0]    c_rw,
  input  logic [NUM_CLIENTS-1:0]    c_read_only,
  input  logic [32*NUM_CLIENTS-1:0] c_data_wr,
  input  logic [8*NUM_CLIENTS-1:0]  c_nbytes,
  input  logic [3*NUM_CLIENTS-1:0]  c_channel,
  output logic [NUM_CLIENTS-1:0]    grant,
  output logic [NUM_CLIENTS-1:0]    done,
  output logic                      error,
  output logic                      timeout,
  output logic [31:0]               rdata,
  output logic                      m_ena,
  output logic                      m_rw,
  output logic                      m_read_only,
  output logic [6:0]                m_addr,
  output logic [31:0]               m_data_wr,
  output logic [7:0]                m_nbytes,
  output logic                      m_reset,
  input  logic [7:0]                m_byte_counter,
  input  logic                      m_busy,
  input  logic                      m_ack_error,
  input  logic [31:0]               m_data_rd
);
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_MUX_SEL, S_GAP, S_XFER, S_WAIT, S_COMPLETE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, owner, winner;
  logic             win_found, cache_hit;
  logic [2:0]       win_ch;
  logic [7:0]       win_nb;
  int               idx;
  logic [31:0]      gap_cnt, wd_cnt;
  logic             mux_phase, err_q, tmo_q, busy_seen_q, ena_q;
  logic             busy_seen, err_now, xact_end, wd_fire;
  logic [7:0]       cur_nbytes;
  logic [6:0]       lat_addr;
  logic             lat_rw, lat_ro;
  logic [31:0]      lat_data;
  logic [7:0]       lat_nbytes;
  logic [2:0]       lat_ch;

  // Walk backwards so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    winner    = rr_ptr;
    win_found = 1'b0;
    idx       = 0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_CLIENTS;
      if (req[idx]) begin
        winner    = IDX_W'(idx);
        win_found = 1'b1;
      end
    end
    win_ch = c_channel[int'(winner)*3 +: 3];
    win_nb = c_nbytes[int'(winner)*8 +: 8];
  end

`ifdef I2C_MUX_CACHE_EN
  logic       cache_vld;
  logic [2:0] cache_ch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld <= 1'b0;
      cache_ch  <= 3'd0;
    end else if (state == S_WAIT) begin
      if (xact_end && mux_phase) begin
        cache_vld <= !err_now;
        cache_ch  <= lat_ch;
      end else if (!xact_end && wd_fire) begin
        cache_vld <= 1'b0;
      end
    end
  end

  assign cache_hit = cache_vld && (cache_ch == win_ch);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    m_ena       = 1'b0;
    m_rw        = 1'b0;
    m_read_only = 1'b0;
    m_addr      = 7'd0;
    m_data_wr   = 32'd0;
    m_nbytes    = 8'd0;
    m_reset     = 1'b0;
    grant       = '0;
    done        = '0;
    error       = 1'b0;
    timeout     = 1'b0;
    xact_end    = 1'b0;
    wd_fire     = 1'b0;
    busy_seen   = busy_seen_q | m_busy;
    err_now     = err_q | m_ack_error;
    cur_nbytes  = mux_phase ? 8'd1 : lat_nbytes;
    if (state inside {S_MUX_SEL, S_GAP, S_XFER, S_WAIT}) begin
      grant[owner] = 1'b1;
      m_addr       = mux_phase ? MUX_ADDR : lat_addr;
      m_data_wr    = mux_phase ? {8'd1 << lat_ch, 24'd0} : lat_data;
      m_rw         = mux_phase ? 1'b0 : lat_rw;
      m_read_only  = mux_phase ? 1'b0 : lat_ro;
      m_nbytes     = cur_nbytes;
    end
    case (state)
      S_IDLE:     if (gap_cnt == 32'd0 && |req) state_nxt = S_ARB;
      S_ARB:      state_nxt = !win_found ? S_IDLE : (cache_hit ? S_XFER : S_MUX_SEL);
      S_MUX_SEL,
      S_XFER: begin
        m_ena     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_GAP:      if (gap_cnt == 32'd0) state_nxt = S_XFER;
      S_WAIT: begin
        // A stale byte count from the previous transfer is ignored until the master has gone busy.
        m_ena    = ena_q && !((busy_seen && m_byte_counter >= cur_nbytes) || err_now);
        xact_end = !m_ena && !m_busy;
        wd_fire  = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'd0);
        if (xact_end) begin
          state_nxt = (mux_phase && !err_now) ? S_GAP : S_COMPLETE;
        end else if (wd_fire) begin
          m_reset   = 1'b1;
          state_nxt = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        done[owner] = 1'b1;
        error       = err_q;
        timeout     = tmo_q;
        state_nxt   = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      gap_cnt     <= 32'd0;
      wd_cnt      <= 32'd0;
      mux_phase   <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      busy_seen_q <= 1'b0;
      ena_q       <= 1'b0;
      rdata       <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (gap_cnt != 32'd0) gap_cnt <= gap_cnt - 32'd1;
        S_ARB: if (win_found) begin
          owner     <= winner;
          rr_ptr    <= (winner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : winner + 1'b1;
          err_q     <= 1'b0;
          tmo_q     <= 1'b0;
          mux_phase <= !cache_hit;
        end
        S_MUX_SEL,
        S_XFER: begin
          wd_cnt      <= 32'(TIMEOUT_CYCLES);
          busy_seen_q <= 1'b0;
          ena_q       <= 1'b1;
        end
        S_GAP: begin
          if (gap_cnt != 32'd0) gap_cnt <= gap_cnt - 32'd1;
          else                  mux_phase <= 1'b0;
        end
        S_WAIT: begin
          busy_seen_q <= busy_seen;
          ena_q       <= m_ena;
          err_q       <= err_now;
          if (wd_cnt != 32'd0) wd_cnt <= wd_cnt - 32'd1;
          if (state_nxt == S_GAP) gap_cnt <= 32'(GAP_CYCLES);
          if (state_nxt == S_COMPLETE) rdata <= m_data_rd;
          if (!xact_end && wd_fire) begin
            err_q <= 1'b1;
            tmo_q <= 1'b1;
          end
        end
        S_COMPLETE: gap_cnt <= 32'(GAP_CYCLES);
        default: ;
      endcase
    end
  end

  // Client fields are held for the whole transaction; zero byte counts become one.
  always_ff @(posedge clk) begin
    if (state == S_ARB && win_found) begin
      lat_addr   <= c_addr[int'(winner)*7 +: 7];
      lat_rw     <= c_rw[winner];
      lat_ro     <= c_read_only[winner];
      lat_data   <= c_data_wr[int'(winner)*32 +: 32];
      lat_nbytes <= (win_nb == 8'd0) ? 8'd1 : win_nb;
      lat_ch     <= win_ch;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: behavioural i2c_master stand-in plus a round-robin/mux-cache reference model.
module tb_i2c_bus_arbiter;
  localparam int N      = 4;
  localparam int GAP    = 500;
  localparam int TMO    = 1000;
  localparam int BYTE_T = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req, c_rw, c_read_only, grant, done;
  logic [7*N-1:0]  c_addr;
  logic [32*N-1:0] c_data_wr;
  logic [8*N-1:0]  c_nbytes;
  logic [3*N-1:0]  c_channel;
  logic            error, timeout, m_ena, m_rw, m_read_only, m_reset, m_busy, m_ack_error;
  logic [31:0]     rdata, m_data_wr, m_data_rd;
  logic [6:0]      m_addr;
  logic [7:0]      m_nbytes, m_byte_counter;

  i2c_bus_arbiter #(.NUM_CLIENTS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .c_addr(c_addr), .c_rw(c_rw),
    .c_read_only(c_read_only), .c_data_wr(c_data_wr), .c_nbytes(c_nbytes),
    .c_channel(c_channel), .grant(grant), .done(done), .error(error),
    .timeout(timeout), .rdata(rdata), .m_ena(m_ena), .m_rw(m_rw),
    .m_read_only(m_read_only), .m_addr(m_addr), .m_data_wr(m_data_wr),
    .m_nbytes(m_nbytes), .m_reset(m_reset), .m_byte_counter(m_byte_counter),
    .m_busy(m_busy), .m_ack_error(m_ack_error), .m_data_rd(m_data_rd)
  );

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic        ro;
    logic [31:0] data;
    logic [7:0]  nb;
  } xact_t;

  xact_t       log_q[$];
  xact_t       ent;
  bit          stuck, nak_mux, nak_client;
  logic [31:0] slave_rd;
  int unsigned tmr;
  logic [7:0]  cur_nb;
  logic        cur_is_mux;
  int          checks, errors;

  assign m_data_rd = slave_rd;

  // i2c_master stand-in: one byte every BYTE_T cycles, idles once ena drops after the last byte.
  always @(posedge clk or posedge reset) begin
    if (reset || m_reset) begin
      m_busy         <= 1'b0;
      m_byte_counter <= 8'd0;
      m_ack_error    <= 1'b0;
    end else if (!m_busy) begin
      m_ack_error <= 1'b0;
      if (m_ena) begin
        m_busy         <= 1'b1;
        m_byte_counter <= 8'd0;
        tmr            <= 0;
        cur_nb         <= m_nbytes;
        cur_is_mux     <= (m_addr == 7'h70);
        ent.addr = m_addr; ent.rw = m_rw; ent.ro = m_read_only;
        ent.data = m_data_wr; ent.nb = m_nbytes;
        log_q.push_back(ent);
      end
    end else if (!stuck) begin
      if (m_byte_counter < cur_nb) begin
        if (tmr == BYTE_T - 1) begin
          tmr            <= 0;
          m_byte_counter <= m_byte_counter + 8'd1;
          if ((cur_is_mux && nak_mux) || (!cur_is_mux && nak_client)) m_ack_error <= 1'b1;
        end else begin
          tmr <= tmr + 1;
        end
      end else if (!m_ena) begin
        m_busy <= 1'b0;
      end
    end
  end

  int       cyc, last_active, min_gap, first_rise, mreset_cnt, mreset_cyc;
  bit       have_active, ena_prev;
  logic [N-1:0] rise_grant;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_ena && !ena_prev) begin
      if (have_active && (cyc - last_active - 1) < min_gap) min_gap = cyc - last_active - 1;
      if (first_rise < 0) first_rise = cyc;
      rise_grant = grant;
    end
    if (m_ena || m_busy) begin
      last_active = cyc;
      have_active = 1'b1;
    end
    if (m_reset) begin
      mreset_cnt = mreset_cnt + 1;
      mreset_cyc = cyc;
    end
    ena_prev = m_ena;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1; req = '0; stuck = 0; nak_mux = 0; nak_client = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    log_q.delete();
    have_active = 0; min_gap = 1_000_000; first_rise = -1; mreset_cnt = 0;
    @(negedge clk);
  endtask

  task automatic set_client(input int i, input logic [6:0] a, input logic rw, input logic ro,
                            input logic [31:0] d, input logic [7:0] nb, input logic [2:0] ch);
    c_addr[i*7 +: 7]     = a;
    c_rw[i]              = rw;
    c_read_only[i]       = ro;
    c_data_wr[i*32 +: 32] = d;
    c_nbytes[i*8 +: 8]   = nb;
    c_channel[i*3 +: 3]  = ch;
  endtask

  task automatic wait_done(output int who, output bit ok);
    ok = 0; who = -1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (done != '0) begin
        ok = 1;
        for (int j = 0; j < N; j++) if (done[j]) who = j;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b1; req = '0;
    @(negedge clk);
    checks++;
    if ({grant, done, error, timeout, m_ena, m_reset, m_rw, m_read_only} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %0h, expected 0", {grant, done, error, timeout, m_ena, m_reset, m_rw, m_read_only});
    end
    checks++;
    if ({rdata, m_addr, m_data_wr, m_nbytes} !== '0) begin
      errors++; $display("FAIL reset_data: got %0h, expected 0", {rdata, m_addr, m_data_wr, m_nbytes});
    end
    do_reset();
    set_client(0, 7'h11, 1'b0, 1'b0, 32'h1234_5678, 8'd3, 3'd1);
    req = 4'b0001;
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (m_ena) seen = 1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (!seen || grant !== '0 || m_ena !== 1'b0 || m_addr !== 7'd0) begin
      errors++; $display("FAIL reset_midxact: seen=%0d grant=%b m_ena=%b, expected seen=1 grant=0 m_ena=0", seen, grant, m_ena);
    end
    checks++;
    if (mreset_cnt !== 0) begin
      errors++; $display("FAIL reset_no_mreset: got %0d m_reset pulses, expected 0", mreset_cnt);
    end
  endtask

  task automatic test_single_read();
    int who; bit ok;
    do_reset();
    set_client(0, 7'h35, 1'b1, 1'b0, 32'h0, 8'd7, 3'd2);
    slave_rd = 32'hA1B2_C3D4;
    req = 4'b0001;
    wait_done(who, ok);
    checks++;
    if (!ok || done !== 4'b0001) begin
      errors++; $display("FAIL single_done: got %b, expected 0001", done);
    end
    checks++;
    if (rdata !== 32'hA1B2_C3D4 || error !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL single_status: got rdata=%h err=%b tmo=%b, expected a1b2c3d4 0 0", rdata, error, timeout);
    end
    checks++;
    if (grant !== '0) begin
      errors++; $display("FAIL single_grant_clear: got %b, expected 0000", grant);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (done !== '0) begin
      errors++; $display("FAIL single_done_width: got %b, expected 0000", done);
    end
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL single_nxact: got %0d, expected 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].addr !== 7'h70 || log_q[0].data[31:24] !== 8'h04 || log_q[0].nb !== 8'd1 || log_q[0].rw !== 1'b0) begin
        errors++; $display("FAIL single_muxwr: got addr=%h d=%h nb=%0d rw=%b, expected 70 04 1 0", log_q[0].addr, log_q[0].data[31:24], log_q[0].nb, log_q[0].rw);
      end
      checks++;
      if (log_q[1].addr !== 7'h35 || log_q[1].rw !== 1'b1 || log_q[1].nb !== 8'd7) begin
        errors++; $display("FAIL single_xfer: got addr=%h rw=%b nb=%0d, expected 35 1 7", log_q[1].addr, log_q[1].rw, log_q[1].nb);
      end
    end
  endtask

  task automatic test_round_robin();
    int who; bit ok;
    do_reset();
    for (int i = 0; i < N; i++) set_client(i, 7'(8'h20 + i), 1'b1, 1'b1, 32'h0, 8'd1, 3'(i));
    req = 4'b1111;
    for (int t = 0; t < 2 * N; t++) begin
      wait_done(who, ok);
      checks++;
      if (!ok || who != (t % N)) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d, expected %0d", t, who, t % N);
      end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    int who; bit ok;
    do_reset();
    stuck = 1;
    set_client(2, 7'h2C, 1'b0, 1'b0, 32'hDEAD_BEEF, 8'd2, 3'd5);
    req = 4'b0100;
    wait_done(who, ok);
    checks++;
    if (!ok || who != 2 || error !== 1'b1 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_status: got who=%0d err=%b tmo=%b, expected 2 1 1", who, error, timeout);
    end
    checks++;
    if (mreset_cnt != 1 || (mreset_cyc - first_rise) != TMO + 1) begin
      errors++; $display("FAIL timeout_mreset: got %0d pulses at +%0d, expected 1 at +%0d", mreset_cnt, mreset_cyc - first_rise, TMO + 1);
    end
    checks++;
    if (log_q.size() != 1) begin
      errors++; $display("FAIL timeout_nxact: got %0d, expected 1", log_q.size());
    end
    stuck = 0;
    req = '0;
  endtask

  task automatic test_mux_nak();
    int who; bit ok;
    do_reset();
    nak_mux = 1;
    set_client(1, 7'h22, 1'b0, 1'b0, 32'hCAFE_0000, 8'd3, 3'd6);
    req = 4'b0010;
    wait_done(who, ok);
    checks++;
    if (!ok || who != 1 || error !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL muxnak_status: got who=%0d err=%b tmo=%b, expected 1 1 0", who, error, timeout);
    end
    checks++;
    if (log_q.size() != 1 || log_q[0].addr !== 7'h70) begin
      errors++; $display("FAIL muxnak_noxfer: got %0d transfers, expected 1 mux write only", log_q.size());
    end
    nak_mux = 0;
    req = '0;
  endtask

  task automatic test_cache();
    int who, nmux, exp_mux; bit ok;
    do_reset();
    set_client(1, 7'h48, 1'b1, 1'b0, 32'h0, 8'd2, 3'd3);
    req = 4'b0010;
    wait_done(who, ok);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    wait_done(who, ok);
    req = '0;
    checks++;
    if (!ok || who != 1 || error !== 1'b0) begin
      errors++; $display("FAIL cache_done: got who=%0d err=%b, expected 1 0", who, error);
    end
    nmux = 0;
    foreach (log_q[i]) if (log_q[i].addr == 7'h70) nmux++;
`ifdef I2C_MUX_CACHE_EN
    exp_mux = 1;
`else
    exp_mux = 2;
`endif
    checks++;
    if (nmux != exp_mux || log_q.size() != exp_mux + 2) begin
      errors++; $display("FAIL cache_muxwrites: got %0d of %0d, expected %0d of %0d", nmux, log_q.size(), exp_mux, exp_mux + 2);
    end
  endtask

  task automatic test_back_to_back();
    int who, n5a; bit ok, nb_ok;
    do_reset();
    set_client(0, 7'h31, 1'b0, 1'b0, 32'h0102_0304, 8'd4, 3'd0);
    set_client(3, 7'h5A, 1'b1, 1'b0, 32'h0, 8'd0, 3'd7);
    req = 4'b1001;
    for (int t = 0; t < 4; t++) begin
      wait_done(who, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL b2b_done[%0d]: got none, expected done", t);
      end
    end
    req = '0;
    checks++;
    if (min_gap < GAP) begin
      errors++; $display("FAIL b2b_gap: got %0d idle cycles, expected >= %0d", min_gap, GAP);
    end
    n5a = 0; nb_ok = 1;
    foreach (log_q[i]) if (log_q[i].addr == 7'h5A) begin
      n5a++;
      if (log_q[i].nb !== 8'd1) nb_ok = 0;
    end
    checks++;
    if (n5a != 2 || !nb_ok) begin
      errors++; $display("FAIL nbytes_zero: got %0d xfers nb_ok=%0d, expected 2 with nbytes 1", n5a, nb_ok);
    end
  endtask

  task automatic test_random();
    int who, w, rr, nexp; bit ok, hit, cache_v;
    bit pend[N];
    logic [6:0] fa[N]; logic frw[N], fro[N]; logic [31:0] fd[N]; logic [7:0] fnb[N]; logic [2:0] fch[N];
    logic [2:0] cache_c;
    do_reset();
    rr = 0; cache_v = 0; cache_c = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0 || (t == 0 && i == N - 1 && req == '0))) begin
          fa[i] = 7'($urandom_range(0, 8'h6F)); frw[i] = 1'($urandom_range(0, 1));
          fro[i] = 1'($urandom_range(0, 1)); fd[i] = $urandom; fnb[i] = 8'($urandom_range(0, 7));
          fch[i] = 3'($urandom_range(0, 7));
          set_client(i, fa[i], frw[i], fro[i], fd[i], fnb[i], fch[i]);
          pend[i] = 1; req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        w = $urandom_range(0, N - 1);
        fa[w] = 7'h0A; frw[w] = 1; fro[w] = 0; fd[w] = 0; fnb[w] = 8'd2; fch[w] = 3'd1;
        set_client(w, fa[w], frw[w], fro[w], fd[w], fnb[w], fch[w]);
        pend[w] = 1; req[w] = 1'b1;
      end
      nak_client = ($urandom_range(0, 3) == 0);
      slave_rd = $urandom;
      w = -1;
      for (int k = N - 1; k >= 0; k--) if (pend[(rr + k) % N]) w = (rr + k) % N;
`ifdef I2C_MUX_CACHE_EN
      hit = cache_v && (cache_c == fch[w]);
`else
      hit = 0;
`endif
      wait_done(who, ok);
      checks++;
      if (!ok || who != w) begin
        errors++; $display("FAIL rand_owner[%0d]: got %0d, expected %0d", t, who, w);
        break;
      end
      checks++;
      if (error !== nak_client || timeout !== 1'b0 || rdata !== slave_rd || grant !== '0) begin
        errors++; $display("FAIL rand_status[%0d]: got err=%b tmo=%b rdata=%h grant=%b, expected %b 0 %h 0", t, error, timeout, rdata, grant, nak_client, slave_rd);
      end
      checks++;
      if (rise_grant !== N'(1 << w)) begin
        errors++; $display("FAIL rand_grant[%0d]: got %b, expected one-hot %0d", t, rise_grant, w);
      end
      nexp = hit ? 1 : 2;
      checks++;
      if (log_q.size() != nexp) begin
        errors++; $display("FAIL rand_nxact[%0d]: got %0d, expected %0d", t, log_q.size(), nexp);
      end else begin
        if (!hit) begin
          checks++;
          if (log_q[0].addr !== 7'h70 || log_q[0].data[31:24] !== 8'(1 << fch[w]) || log_q[0].nb !== 8'd1) begin
            errors++; $display("FAIL rand_mux[%0d]: got addr=%h d=%h, expected 70 %h", t, log_q[0].addr, log_q[0].data[31:24], 8'(1 << fch[w]));
          end
        end
        checks++;
        if (log_q[nexp-1].addr !== fa[w] || log_q[nexp-1].rw !== frw[w] || log_q[nexp-1].ro !== fro[w] ||
            log_q[nexp-1].data !== fd[w] || log_q[nexp-1].nb !== ((fnb[w] == 0) ? 8'd1 : fnb[w])) begin
          errors++; $display("FAIL rand_xfer[%0d]: got addr=%h nb=%0d, expected %h %0d", t, log_q[nexp-1].addr, log_q[nexp-1].nb, fa[w], fnb[w]);
        end
      end
      log_q.delete();
      rr = (w + 1) % N;
      cache_v = 1; cache_c = fch[w];
      pend[w] = 0; req[w] = 1'b0;
    end
    req = '0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ena_prev = 0; rise_grant = '0;
    have_active = 0; min_gap = 1_000_000; first_rise = -1; mreset_cnt = 0; mreset_cyc = 0;
    req = '0; c_addr = '0; c_rw = '0; c_read_only = '0; c_data_wr = '0; c_nbytes = '0; c_channel = '0;
    stuck = 0; nak_mux = 0; nak_client = 0; slave_rd = 32'd0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_mux_nak();
    test_cache();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
